// File: rtl/simd_result_unpacker_if.sv
// Handshake and data bundle between the SIMD ALU result stage, the unpacker and downstream logic.
// The slave modport is the unpacker's view; master is the view of whatever drives and consumes it.
interface simd_result_unpacker_if #(
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 8
);
    localparam int DATA_W = SLICE_W * NUM_SLICES;

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            USE_SIMD;
    logic [DATA_W-1:0]     S;
    logic [NUM_SLICES-1:0] result_SIDM_carry_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_lane;
    logic                  out_carry;
    logic [2:0]            out_lane_idx;
    logic                  out_last;

    modport slave (
        input  in_valid, USE_SIMD, S, result_SIDM_carry_out, out_ready,
        output in_ready, out_valid, out_lane, out_carry, out_lane_idx, out_last
    );

    modport master (
        output in_valid, USE_SIMD, S, result_SIDM_carry_out, out_ready,
        input  in_ready, out_valid, out_lane, out_carry, out_lane_idx, out_last
    );
endinterface

// File: rtl/simd_result_unpacker.sv
// Captures one SIMD ALU result word with its slice carries and streams it out as 1/2/4/8 lanes,
// one lane per cycle, each lane carrying the carry-out of its top slice.
//
// state | meaning
// IDLE  | no word held, in_ready=1, out_valid=0
// DRAIN | word held, presenting lane cnt_q
module simd_result_unpacker #(
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 8,
    parameter int SIGN_EXT   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    simd_result_unpacker_if.slave bus
);
    localparam int DATA_W = SLICE_W * NUM_SLICES;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     buf_q, buf_d;
    logic [NUM_SLICES-1:0] cbuf_q, cbuf_d;
    logic [1:0]            mode_q, mode_d;
    logic [2:0]            cnt_q, cnt_d;

    int                    lane_w;
    int                    lane_slices;
    int                    lane_off;
    logic [DATA_W-1:0]     lane_shifted;
    logic [DATA_W-1:0]     msb_shifted;
    logic [NUM_SLICES-1:0] carry_shifted;
    logic [DATA_W-1:0]     lane_val;
    logic                  carry_val;
    logic [2:0]            last_idx;
    logic                  is_last;
    logic                  valid;
    logic                  ready;
    logic                  capture;

    // Lane extraction works purely from the latched word, mode and counter.
    always_comb begin
        lane_w        = DATA_W >> mode_q;
        lane_slices   = NUM_SLICES >> mode_q;
        lane_off      = int'(cnt_q) * lane_w;
        lane_shifted  = buf_q >> lane_off;
        msb_shifted   = buf_q >> (lane_off + lane_w - 1);
        carry_shifted = cbuf_q >> ((int'(cnt_q) + 1) * lane_slices - 1);
        carry_val     = carry_shifted[0];
        lane_val      = '0;
        for (int b = 0; b < DATA_W; b++) begin
            if (b < lane_w) begin
                lane_val[b] = lane_shifted[b];
            end else if (SIGN_EXT != 0) begin
                lane_val[b] = msb_shifted[0];
            end
        end
        last_idx = 3'((1 << mode_q) - 1);
    end

    assign is_last = (cnt_q == last_idx);
    assign valid   = (state_q == DRAIN);
    assign ready   = !valid || (bus.out_ready && is_last);
    assign capture = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cbuf_d  = cbuf_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A capture on the last-lane handshake overrides the return to IDLE.
        if (capture) begin
            state_d = DRAIN;
            buf_d   = bus.S;
            cbuf_d  = bus.result_SIDM_carry_out;
            mode_d  = bus.USE_SIMD;
            cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cbuf_q  <= '0;
            mode_q  <= 2'b00;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cbuf_q  <= cbuf_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.out_valid    = valid;
    assign bus.out_lane     = valid ? lane_val : '0;
    assign bus.out_carry    = valid && carry_val;
    assign bus.out_lane_idx = valid ? cnt_q : 3'd0;
    assign bus.out_last     = valid && is_last;
endmodule

// File: tb/tb_simd_result_unpacker.sv
// Bench for simd_result_unpacker: zero- and sign-extending instances share one stimulus stream
// and are compared every cycle against a queue of expected lanes built from each captured word.
module tb_simd_result_unpacker;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    simd_result_unpacker_if #(.SLICE_W(4), .NUM_SLICES(8)) bus0 ();
    simd_result_unpacker_if #(.SLICE_W(4), .NUM_SLICES(8)) bus1 ();

    assign bus1.in_valid              = bus0.in_valid;
    assign bus1.USE_SIMD              = bus0.USE_SIMD;
    assign bus1.S                     = bus0.S;
    assign bus1.result_SIDM_carry_out = bus0.result_SIDM_carry_out;
    assign bus1.out_ready             = bus0.out_ready;

    simd_result_unpacker #(.SLICE_W(4), .NUM_SLICES(8), .SIGN_EXT(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    simd_result_unpacker #(.SLICE_W(4), .NUM_SLICES(8), .SIGN_EXT(1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] lz;
        logic [31:0] ls;
        logic        c;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    beat_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected lanes of one word, straight from the lane-splitting rules.
    task automatic push_word(input logic [1:0] mode, input logic [31:0] s, input logic [7:0] c);
        int n, lw, spl;
        logic [63:0] mask;
        logic [31:0] raw;
        beat_t b;
        n    = 1 << mode;
        lw   = 32 / n;
        spl  = 8 / n;
        mask = (64'd1 << lw) - 64'd1;
        for (int i = 0; i < n; i++) begin
            raw    = (s >> (i * lw)) & mask[31:0];
            b.lz   = raw;
            b.ls   = ((raw >> (lw - 1)) & 32'd1) != 0 ? (raw | ~mask[31:0]) : raw;
            b.c    = ((c >> ((i + 1) * spl - 1)) & 8'd1) != 0;
            b.idx  = 3'(i);
            b.last = (i == n - 1);
            q.push_back(b);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] mode, input logic [31:0] s,
                         input logic [7:0] c, input logic rdy);
        bus0.in_valid              = v;
        bus0.USE_SIMD              = mode;
        bus0.S                     = s;
        bus0.result_SIDM_carry_out = c;
        bus0.out_ready             = rdy;
    endtask

    task automatic step(input bit zero_chk);
        bit    exp_v;
        bit    exp_r;
        beat_t f;
        f = '0;
        @(negedge clk);
        exp_v = (q.size() != 0);
        if (exp_v) f = q[0];
        exp_r = !exp_v || (bus0.out_ready && f.last);
        chk("out_valid_z", 32'(bus0.out_valid), 32'(exp_v));
        chk("out_valid_s", 32'(bus1.out_valid), 32'(exp_v));
        chk("in_ready_z", 32'(bus0.in_ready), 32'(exp_r));
        chk("in_ready_s", 32'(bus1.in_ready), 32'(exp_r));
        if (exp_v) begin
            chk("out_lane_z", bus0.out_lane, f.lz);
            chk("out_lane_s", bus1.out_lane, f.ls);
            chk("out_carry", 32'(bus0.out_carry), 32'(f.c));
            chk("out_carry_s", 32'(bus1.out_carry), 32'(f.c));
            chk("out_lane_idx", 32'(bus0.out_lane_idx), 32'(f.idx));
            chk("out_last", 32'(bus0.out_last), 32'(f.last));
        end
        if (zero_chk) begin
            chk("rst_lane", bus0.out_lane, 32'd0);
            chk("rst_carry", 32'(bus0.out_carry), 32'd0);
            chk("rst_idx", 32'(bus0.out_lane_idx), 32'd0);
            chk("rst_last", 32'(bus0.out_last), 32'd0);
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (exp_v && bus0.out_ready) void'(q.pop_front());
            if (bus0.in_valid && exp_r) push_word(bus0.USE_SIMD, bus0.S, bus0.result_SIDM_carry_out);
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        step(1'b1);

        // Mode 11: eight nibble lanes
        drive(1'b1, 2'b11, 32'h76543210, 8'b10000001, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        repeat (8) step(1'b0);

        // Mode 01: two halfword lanes
        drive(1'b1, 2'b01, 32'hABCD1234, 8'b10001000, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        repeat (2) step(1'b0);

        // Mode 00: back-to-back full words
        drive(1'b1, 2'b00, 32'h11111111, 8'h00, 1'b1);
        step(1'b0);
        drive(1'b1, 2'b00, 32'h22222222, 8'h80, 1'b1);
        step(1'b0);
        drive(1'b1, 2'b00, 32'h33333333, 8'h00, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        repeat (2) step(1'b0);

        // Mode 10 with backpressure at lane 1 and mode/data churn mid-drain
        drive(1'b1, 2'b10, 32'h80FF7F01, 8'h00, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b10, 32'h0, 8'h0, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b11, 32'hDEADBEEF, 8'hFF, 1'b0);
        repeat (3) step(1'b0);
        drive(1'b1, 2'b11, 32'hCAFEF00D, 8'h55, 1'b1);
        step(1'b0);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        step(1'b0);

        // Mode 10 with a new word taken on the last-lane handshake
        drive(1'b1, 2'b10, 32'h44332211, 8'hAA, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b10, 32'h0, 8'h0, 1'b1);
        repeat (3) step(1'b0);
        drive(1'b1, 2'b10, 32'h88776655, 8'h22, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        repeat (4) step(1'b0);

        // Reset at lane 2 of a mode-11 word, then restart
        drive(1'b1, 2'b11, 32'h9ABCDEF0, 8'hF0, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        repeat (2) step(1'b0);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        step(1'b1);
        drive(1'b1, 2'b11, 32'h0F1E2D3C, 8'h3C, 1'b1);
        step(1'b0);
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        repeat (8) step(1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
            step(1'b0);
        end
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 8'h0, 1'b1);
        repeat (10) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
